serial_subtractor: RTL

- Bit-serial, LSB-first WIDTH-bit subtractor computing diff = a - b. It is the inverse operation of the team's adder cells.
- One full-subtractor cell plus a borrow flip-flop evaluates one bit per clock.
- Sits beside the CLA/ripple adders as the area-minimal subtract path for the ALU datapath.
- Operands load in parallel; result is presented in parallel with a start/busy/done handshake.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Optional overflow flag exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock through a
// single full-subtractor cell and a borrow flip-flop.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow flag ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bnext;
  logic             w_busy;
  logic             w_done;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_ovf;
`endif

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // Full-subtractor cell on the current LSBs
  assign w_d     = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bnext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = w_accept ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand shift registers, borrow, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_cnt    <= r_cnt + CW'(1);
      r_borrow <= w_bnext;
      if (w_last) r_bout <= w_bnext;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign capture and overflow evaluation; the result MSB is the bit
  // being produced on the last RUN cycle, so ovf settles entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_amsb <= bus.a[WIDTH-1];
      r_bmsb <= bus.b[WIDTH-1];
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_ovf  <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
endmodule
